isqrt_seq: RTL and testbench
============================

Name: isqrt_seq

Overview:
Sequential integer square-root unit: the inverse of the team's combinational squarer. Accepts a WIDTH-bit unsigned radicand and returns floor(sqrt(x)) plus remainder x - root^2. Uses a restoring digit-by-digit algorithm, one root bit per cycle. Sits behind a valid/ready handshake on both sides, so it can feed or be fed by the squarer datapath and other arithmetic blocks.

Parameters:
WIDTH, 8, radicand width; must be even and >= 2; root width RW = WIDTH/2, remainder width REMW = WIDTH/2+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  radicand valid
in_ready  out  1  unit can accept a radicand
in_data  in  WIDTH  unsigned radicand
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_root  out  RW  floor(sqrt(in_data))
out_rem  out  REMW  in_data - out_root^2, range 0..2*out_root
chk_err  out  1  sticky self-check failure (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-low. When rst_n=0: state=IDLE, in_ready=1, out_valid=0, out_root=0, out_rem=0, chk_err=0, and all internal registers are cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready the unit latches in_data into the shift register, clears the partial root and partial remainder, loads iter_cnt=RW-1, and moves to CALC.
- CALC: in_ready=0 and out_valid=0. One iteration per cycle:
  - r' = (rem<<2) | top 2 bits of the shift register; shift the register left by 2.
  - t = (root<<2) | 1.
  - If r' >= t: rem = r'-t, root = (root<<1)|1. Otherwise rem = r', root = root<<1.
  - The internal remainder is REMW+1 bits wide; no truncation is allowed during iteration.
  - At iter_cnt==0 the unit writes out_root and out_rem (low REMW bits) and moves to DONE. Otherwise iter_cnt decrements.
- Latency: accept at edge N, iterations at edges N+1..N+RW, out_valid=1 after edge N+RW. With WIDTH=8, out_valid is high 4 cycles after accept.
- DONE: out_valid=1, in_ready=0. out_root and out_rem hold stable while out_ready=0, for any number of cycles. On out_valid&&out_ready the unit moves to IDLE.
- No bypass: the earliest next accept is the cycle after the output handshake. Throughput is one result per RW+2 cycles.
- out_root and out_rem retain the last result after the handshake until the next result overwrites them.
- in_data is ignored outside IDLE and may change freely.
- Boundaries:
  - in_data=0 gives root 0, rem 0.
  - in_data=2^WIDTH-1 gives root 2^RW-1, rem 2^(RW+1)-2 (the maximum remainder, which fits REMW).
- Reset mid-CALC or mid-DONE aborts immediately: the result is lost and the FSM returns to IDLE with the reset values above.
- in_valid asserted during reset is not captured.

Optional Feature:
Macro ISQRT_SELF_CHECK_EN.
- Defined: the original radicand is kept in a shadow register. On entry to DONE, combinational logic computes out_root*out_root + out_rem and compares it with the shadow value, and checks out_rem <= 2*out_root. On any mismatch chk_err is set at that edge. chk_err stays high until reset.
- Not defined: no shadow register or check logic is built, and chk_err is tied 0.
- Port list is identical in both builds.

Decomposition:
- Package isqrt_pkg:
  - state typedef (IDLE/CALC/DONE).
  - localparam functions for RW and REMW from WIDTH.
  - iteration-counter width constant, clog2(RW), minimum 1.
- Sub-module isqrt_step:
  - purely combinational single iteration.
  - inputs: rem, root, 2 radicand bits.
  - outputs: next rem, next root.
  - instanced once in isqrt_seq; reusable for a future unrolled, pipelined variant.

Test Plan (WIDTH=8 unless stated):
- in_data=225, out_ready=1 -> out_valid exactly 4 cycles after accept, root=15, rem=0, then in_ready=1 the following cycle.
- in_data=255, 200, 2, 0 back-to-back with in_valid held high -> (15,30), (14,4), (1,1), (0,0) in order, one result per 6 cycles.
- in_data=99 with out_ready=0 for 7 cycles after out_valid -> root=9 and rem=18 held stable, in_ready=0 throughout, single handshake when out_ready rises.
- rst_n pulsed low 2 cycles after accepting 144 -> out_valid stays 0, all outputs return to 0 immediately, next input 16 gives (4,0).
- Exhaustive sweep 0..255 with random out_ready stalls -> root^2+rem==x and rem<=2*root for every x. Under ISQRT_SELF_CHECK_EN, chk_err remains 0.
- WIDTH=16: in_data=65535 -> root=255, rem=510, latency 8 cycles.

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int root_w(input int width);
        return width / 2;
    endfunction

    function automatic int rem_w(input int width);
        return width / 2 + 1;
    endfunction

    // Iteration counter counts RW-1 down to 0; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: brings in two radicand bits, yields one root bit.
// Purely combinational, no handshake.
module isqrt_step #(
    parameter int RW   = 4,
    parameter int REMW = RW + 1
) (
    input  logic [REMW:0]   rem,
    input  logic [RW-1:0]   root,
    input  logic [1:0]      bits,
    output logic [REMW:0]   next_rem,
    output logic [RW-1:0]   next_root
);

    // Trial values carry two extra bits so the shifted remainder never truncates.
    localparam int XW = REMW + 3;
    localparam int LW = REMW + 1;

    logic [XW-1:0] r_shift;
    logic [XW-1:0] trial;
    logic          ge;

    assign r_shift   = {rem, bits};
    assign trial     = XW'({root, 2'b01});
    assign ge        = (r_shift >= trial);
    assign next_rem  = ge ? LW'(r_shift - trial) : LW'(r_shift);
    assign next_root = RW'({root, ge});

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor(sqrt(x)) with remainder; one root bit per cycle, result RW cycles after accept.
// Valid/ready both sides, results held until taken; ISQRT_SELF_CHECK_EN adds a sticky result check.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [root_w(WIDTH)-1:0]   out_root,
    output logic [rem_w(WIDTH)-1:0]    out_rem,
    output logic                       chk_err
);

    localparam int RW   = root_w(WIDTH);
    localparam int REMW = rem_w(WIDTH);
    localparam int CW   = cnt_w(WIDTH);

    state_t          state_q;
    state_t          state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [REMW:0]    rem_q;
    logic [RW-1:0]    root_q;
    logic [CW-1:0]    cnt_q;
    logic [REMW:0]    nrem;
    logic [RW-1:0]    nroot;
    logic             accept;
    logic             last_iter;

    assign accept    = in_valid && in_ready;
    assign last_iter = (state_q == CALC) && (cnt_q == '0);

    isqrt_step #(
        .RW   (RW),
        .REMW (REMW)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .bits      (sreg_q[WIDTH-1 -: 2]),
        .next_rem  (nrem),
        .next_root (nroot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q   <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            cnt_q    <= '0;
            out_root <= '0;
            out_rem  <= '0;
        end else if (accept) begin
            sreg_q <= in_data;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CW'(RW - 1);
        end else if (state_q == CALC) begin
            sreg_q <= sreg_q << 2;
            rem_q  <= nrem;
            root_q <= nroot;
            if (cnt_q == '0) begin
                out_root <= nroot;
                out_rem  <= REMW'(nrem);
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef ISQRT_SELF_CHECK_EN
    // Checks the values being written into the result registers on the DONE-entry edge.
    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] shadow_q;
    logic             chk_q;
    logic             mismatch;

    assign mismatch = ((PW'(nroot) * PW'(nroot) + PW'(nrem)) != PW'(shadow_q))
                   || (nrem > (REMW + 1)'({nroot, 1'b0}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            chk_q    <= 1'b0;
        end else begin
            if (accept) shadow_q <= in_data;
            if (last_iter && mismatch) chk_q <= 1'b1;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// Randomized and directed bench for isqrt_seq (WIDTH=8 plus a WIDTH=16 instance).
module tb_isqrt_seq;

    localparam int RW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, chk_err;
    logic [7:0] in_data;
    logic [3:0] out_root;
    logic [4:0] out_rem;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_chk_err;
    logic [15:0] w_in_data;
    logic [7:0]  w_out_root;
    logic [8:0]  w_out_rem;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    isqrt_seq #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .chk_err(chk_err)
    );

    isqrt_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_root(w_out_root), .out_rem(w_out_rem), .chk_err(w_chk_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: largest r with r*r <= x, found by counting up.
    function automatic int ref_root(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return int'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int x, input int stall);
        int r, m, lat, guard;
        r = ref_root(x);
        m = x - r * r;
        in_data  = 8'(x);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin tick(); guard++; end
        check("accept_wait", guard < 50, 1);
        tick();
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        out_ready = (stall == 0);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("latency", lat, RW);
        check("root", out_root, r);
        check("rem", out_rem, m);
        check("identity", (int'(out_root) * int'(out_root) + int'(out_rem) == x)
                          && (int'(out_rem) <= 2 * int'(out_root)), 1);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_vld", out_valid, 1);
            check("hold_rdy", in_ready, 0);
            check("hold_root", out_root, r);
            check("hold_rem", out_rem, m);
        end
        out_ready = 1'b1;
        tick();
        check("hs_vld", out_valid, 0);
        check("hs_rdy", in_ready, 1);
        check("keep_root", out_root, r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int vals[4];
        int acc, prev, guard, lat, r;
        vals = '{255, 200, 2, 0};
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_root", out_root, 0);
        check("rst_rem", out_rem, 0);
        check("rst_chk", chk_err, 0);
        check("rst_w_ready", w_in_ready, 1);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        xfer(225, 0);

        // Back-to-back with in_valid held high: accepts should be 6 cycles apart.
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(vals[i]);
            guard = 0;
            while (!in_ready && guard < 50) begin tick(); guard++; end
            tick();
            acc = cyc;
            if (i > 0) check("b2b_period", acc - prev, 6);
            prev = acc;
            in_data = 8'($urandom);
            guard = 0;
            while (!out_valid && guard < 50) begin tick(); guard++; end
            r = ref_root(vals[i]);
            check("b2b_root", out_root, r);
            check("b2b_rem", out_rem, vals[i] - r * r);
        end
        in_valid = 1'b0;
        tick();
        check("b2b_idle", in_ready, 1);

        xfer(99, 7);

        // Reset mid-calculation discards the job and clears outputs asynchronously.
        in_data = 8'd144; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("arst_vld", out_valid, 0);
        check("arst_rdy", in_ready, 1);
        check("arst_root", out_root, 0);
        check("arst_rem", out_rem, 0);
        in_valid = 1'b1; in_data = 8'd77;
        tick(); tick();
        check("arst_nocap_rdy", in_ready, 1);
        check("arst_nocap_vld", out_valid, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_rdy", in_ready, 1);
        xfer(16, 0);

        for (int x = 0; x < 256; x++) xfer(x, int'($urandom_range(0, 2)));
        check("chk_err_clear", chk_err, 0);

        // WIDTH=16 instance: maximum radicand.
        w_in_data = 16'hFFFF; w_in_valid = 1'b1; w_out_ready = 1'b1;
        tick();
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 50) begin tick(); lat++; end
        r = ref_root(65535);
        check("w16_latency", lat, 8);
        check("w16_root", w_out_root, r);
        check("w16_rem", w_out_rem, 65535 - r * r);
        tick();
        check("w16_hs", w_in_ready, 1);
        check("w16_chk", w_chk_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
